// File: rtl/battleship_pkg.sv
// Shared types, board constants and helpers for the Battleship shot resolver.
package battleship_pkg;

  localparam int unsigned BOARD_N     = 10;
  localparam int unsigned TOTAL_CELLS = 17;

  // 0 water, 1 destroyer, 2 submarine, 3 cruiser, 4 battleship, 5 carrier
  typedef logic [2:0] ship_id_t;

  typedef enum logic [1:0] {StIdle, StScan, StUpdate} state_t;

  // Indexed [y][x]; both axes run 1..BOARD_N.
  localparam ship_id_t SHIP_MAP [1:10][1:10] = '{
    '{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4},
    '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4},
    '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd4},
    '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd4},
    '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd0, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd0}
  };

  // Flat hit-map bit for an on-board cell, row-major from (1,1).
  function automatic logic [6:0] cell_index(input logic [3:0] cx, input logic [3:0] cy);
    return 7'(({3'b000, cy} - 7'd1) * 7'(BOARD_N) + {3'b000, cx} - 7'd1);
  endfunction

  // Keep only the highest set bit.
  function automatic logic [4:0] top_onehot(input logic [4:0] m);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      if (m[i]) r = 5'd1 << i;
    end
    return r;
  endfunction

endpackage

// File: rtl/shot_resolver_if.sv
// Switch/key inputs and display-facing outputs of the shot resolver.
interface shot_resolver_if;
  logic [3:0] x;
  logic [3:0] y;
  logic       big;
  logic [1:0] big_left;
  logic       score_L;
  logic       hit;
  logic       near_miss;
  logic       miss;
  logic       wrong;
  logic [4:0] num_hits;
  logic [3:0] hits_bcd;
  logic [4:0] biggest_ship_hit;
  logic       busy;
  logic       game_over;

  modport master (
    output x, y, big, big_left, score_L,
    input  hit, near_miss, miss, wrong, num_hits, hits_bcd, biggest_ship_hit, busy, game_over
  );

  modport slave (
    input  x, y, big, big_left, score_L,
    output hit, near_miss, miss, wrong, num_hits, hits_bcd, biggest_ship_hit, busy, game_over
  );
endinterface

// File: rtl/board_lookup.sv
// Combinational ship lookup; anything off the board reads as water.
module board_lookup
  import battleship_pkg::*;
(
  input  logic signed [5:0] x,
  input  logic signed [5:0] y,
  output ship_id_t          ship
);

  logic on_board;

  // Bounds check, then table read.
  always_comb begin
    on_board = (x >= 6'sd1) && (x <= $signed(6'(BOARD_N))) &&
               (y >= 6'sd1) && (y <= $signed(6'(BOARD_N)));
    ship = '0;
    if (on_board) ship = SHIP_MAP[y[3:0]][x[3:0]];
  end

endmodule

// File: rtl/shot_resolver.sv
// Fire-key front end, board scan FSM and game state for Battleship.
module shot_resolver
  import battleship_pkg::*;
(
  input logic            clock,
  input logic            reset_L,
  shot_resolver_if.slave bus
);

  state_t       state;
  logic [2:0]   sync;
  logic [3:0]   tx, ty;
  logic         rad;
  logic [2:0]   col, row;
  logic [3:0]   new_hits;
  logic         near;
  logic [4:0]   ship_mask;
  logic [99:0]  hit_map;
  logic         hit, near_miss, miss, wrong, busy;
  logic [4:0]   num_hits, biggest;

  logic              fire, legal, fresh, target;
  logic [2:0]        last;
  logic [1:0]        off;
  logic signed [5:0] cx, cy;
  logic [6:0]        idx;
  logic [5:0]        sum;
  ship_id_t          cell_ship;

  board_lookup u_board_lookup (
    .x    (cx),
    .y    (cy),
    .ship (cell_ship)
  );

  // Fire pulse, request legality and current scan-cell decode.
  always_comb begin
    fire  = sync[2] & ~sync[1];
    legal = (bus.x >= 4'd1) && (bus.x <= 4'(BOARD_N)) &&
            (bus.y >= 4'd1) && (bus.y <= 4'(BOARD_N)) &&
            (bus.big_left != 2'd3) && !(bus.big && (bus.big_left == 2'd0));
    last   = rad ? 3'd4 : 3'd2;
    off    = rad ? 2'd2 : 2'd1;
    cx     = {2'b00, tx} + {3'b000, col} - {4'b0000, off};
    cy     = {2'b00, ty} + {3'b000, row} - {4'b0000, off};
    idx    = cell_index(cx[3:0], cy[3:0]);
    // Only on-board cells can be non-water, so idx is in range whenever fresh matters.
    fresh  = (cell_ship != '0) && !hit_map[idx];
    // The outer ring of the window is the probe ring; everything inside is targeted.
    target = (col != 3'd0) && (col != last) && (row != 3'd0) && (row != last);
    sum    = {1'b0, num_hits} + {2'b00, new_hits};
  end

  // Key synchronizer, scan FSM and registered results.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state     <= StIdle;
      sync      <= 3'b111;
      tx        <= '0;
      ty        <= '0;
      rad       <= 1'b0;
      col       <= '0;
      row       <= '0;
      new_hits  <= '0;
      near      <= 1'b0;
      ship_mask <= '0;
      hit_map   <= '0;
      hit       <= 1'b0;
      near_miss <= 1'b0;
      miss      <= 1'b0;
      wrong     <= 1'b0;
      busy      <= 1'b0;
      num_hits  <= '0;
      biggest   <= '0;
    end else begin
      sync <= {sync[1:0], bus.score_L};
      unique case (state)
        StIdle: begin
          if (fire) begin
            if (!legal) begin
              wrong     <= 1'b1;
              hit       <= 1'b0;
              near_miss <= 1'b0;
              miss      <= 1'b0;
              biggest   <= '0;
            end else begin
              tx        <= bus.x;
              ty        <= bus.y;
              rad       <= bus.big;
              col       <= '0;
              row       <= '0;
              new_hits  <= '0;
              near      <= 1'b0;
              ship_mask <= '0;
              busy      <= 1'b1;
              wrong     <= 1'b0;
              state     <= StScan;
            end
          end
        end
        StScan: begin
          if (fresh) begin
            if (target) begin
              new_hits     <= new_hits + 4'd1;
              hit_map[idx] <= 1'b1;
              ship_mask    <= ship_mask | (5'd1 << (cell_ship - 3'd1));
            end else begin
              near <= 1'b1;
            end
          end
          if (col == last) begin
            col <= '0;
            if (row == last) state <= StUpdate;
            else             row   <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end
        StUpdate: begin
          num_hits  <= (sum > 6'(TOTAL_CELLS)) ? 5'(TOTAL_CELLS) : sum[4:0];
          hit       <= (new_hits != 4'd0);
          near_miss <= (new_hits == 4'd0) && near;
          miss      <= (new_hits == 4'd0) && !near;
          biggest   <= top_onehot(ship_mask);
          busy      <= 1'b0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.hit              = hit;
  assign bus.near_miss        = near_miss;
  assign bus.miss             = miss;
  assign bus.wrong            = wrong;
  assign bus.num_hits         = num_hits;
  assign bus.hits_bcd         = (num_hits > 5'd9) ? 4'd9 : num_hits[3:0];
  assign bus.biggest_ship_hit = biggest;
  assign bus.busy             = busy;
  assign bus.game_over        = (num_hits == 5'(TOTAL_CELLS));

endmodule

// File: tb/tb_shot_resolver.sv
// Self-checking bench for shot_resolver: vector table plus reset-mid-scan sequence.
module tb_shot_resolver;

  logic clock;
  logic reset_L;
  int   checks;
  int   errors;

  shot_resolver_if bus ();

  shot_resolver dut (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       big;
    logic [1:0] bl;
    logic       repress;
    logic [3:0] res;   // {hit, near_miss, miss, wrong}
    logic [4:0] num;
    logic [4:0] bsh;
  } vec_t;

  typedef struct packed {
    logic [3:0] res;
    logic [4:0] num;
    logic [4:0] bsh;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_results(input string tag, input exp_t ex);
    logic [3:0] bcd;
    bcd = (ex.num > 5'd9) ? 4'd9 : ex.num[3:0];
    check({tag, ".hit"},   32'(bus.hit),              32'(ex.res[3]));
    check({tag, ".near"},  32'(bus.near_miss),        32'(ex.res[2]));
    check({tag, ".miss"},  32'(bus.miss),             32'(ex.res[1]));
    check({tag, ".wrong"}, 32'(bus.wrong),            32'(ex.res[0]));
    check({tag, ".num"},   32'(bus.num_hits),         32'(ex.num));
    check({tag, ".bcd"},   32'(bus.hits_bcd),         32'(bcd));
    check({tag, ".bsh"},   32'(bus.biggest_ship_hit), 32'(ex.bsh));
    check({tag, ".over"},  32'(bus.game_over),        32'(ex.num == 5'd17));
    check({tag, ".busy"},  32'(bus.busy),             32'd0);
  endtask

  // Press and hold the key, follow the shot to its result, then release.
  task automatic do_shot(input string tag, input vec_t v);
    exp_t ex;
    int   pos;
    int   n;
    sb.push_back('{res: v.res, num: v.num, bsh: v.bsh});
    @(negedge clock);
    bus.x        = v.x;
    bus.y        = v.y;
    bus.big      = v.big;
    bus.big_left = v.bl;
    bus.score_L  = 1'b0;
    repeat (3) @(negedge clock);
    pos = 2;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    ex = sb.pop_front();
    if (v.res[0]) begin
      check_results(tag, ex);
    end else begin
      check({tag, ".start_busy"},  32'(bus.busy),  32'd1);
      check({tag, ".start_wrong"}, 32'(bus.wrong), 32'd0);
      // Switch changes mid-scan must not matter.
      bus.x   = 4'd1;
      bus.y   = 4'd1;
      bus.big = ~v.big;
      if (v.repress) begin
        bus.score_L = 1'b1;
        repeat (2) @(negedge clock);
        pos = 4;
        bus.score_L = 1'b0;
      end
      n = v.big ? 25 : 9;
      repeat (n + 2 - pos) @(negedge clock);
      check({tag, ".late_busy"}, 32'(bus.busy), 32'd1);
      @(negedge clock);
      check_results(tag, ex);
    end
    bus.score_L = 1'b1;
    repeat (4) @(negedge clock);
    check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t rv;
    checks = 0;
    errors = 0;
    //          x      y      big   bl     rep   res       num     bsh
    vecs[0]  = '{4'd3,  4'd1,  1'b0, 2'd0, 1'b0, 4'b1000, 5'd1,  5'b10000};
    vecs[1]  = '{4'd3,  4'd1,  1'b0, 2'd0, 1'b0, 4'b0100, 5'd1,  5'b00000};
    vecs[2]  = '{4'd8,  4'd4,  1'b0, 2'd0, 1'b1, 4'b0010, 5'd1,  5'b00000};
    vecs[3]  = '{4'd9,  4'd4,  1'b1, 2'd2, 1'b0, 4'b1000, 5'd4,  5'b01000};
    vecs[4]  = '{4'd0,  4'd4,  1'b0, 2'd1, 1'b0, 4'b0001, 5'd4,  5'b00000};
    vecs[5]  = '{4'd4,  4'd11, 1'b0, 2'd1, 1'b0, 4'b0001, 5'd4,  5'b00000};
    vecs[6]  = '{4'd5,  4'd5,  1'b1, 2'd0, 1'b0, 4'b0001, 5'd4,  5'b00000};
    vecs[7]  = '{4'd5,  4'd5,  1'b0, 2'd3, 1'b0, 4'b0001, 5'd4,  5'b00000};
    vecs[8]  = '{4'd6,  4'd5,  1'b0, 2'd0, 1'b0, 4'b1000, 5'd5,  5'b00001};
    vecs[9]  = '{4'd10, 4'd10, 1'b0, 2'd0, 1'b0, 4'b0100, 5'd5,  5'b00000};
    vecs[10] = '{4'd2,  4'd9,  1'b1, 2'd1, 1'b0, 4'b1000, 5'd7,  5'b00100};
    vecs[11] = '{4'd1,  4'd1,  1'b1, 2'd1, 1'b0, 4'b1000, 5'd9,  5'b10000};
    vecs[12] = '{4'd4,  4'd1,  1'b1, 2'd1, 1'b0, 4'b1000, 5'd11, 5'b10000};
    vecs[13] = '{4'd10, 4'd6,  1'b1, 2'd2, 1'b0, 4'b1000, 5'd12, 5'b01000};
    vecs[14] = '{4'd8,  4'd10, 1'b1, 2'd2, 1'b0, 4'b1000, 5'd15, 5'b00010};
    vecs[15] = '{4'd6,  4'd6,  1'b0, 2'd0, 1'b0, 4'b1000, 5'd16, 5'b00001};
    vecs[16] = '{4'd4,  4'd8,  1'b0, 2'd0, 1'b0, 4'b1000, 5'd17, 5'b00100};
    vecs[17] = '{4'd4,  4'd8,  1'b0, 2'd0, 1'b0, 4'b0010, 5'd17, 5'b00000};

    bus.x        = 4'd0;
    bus.y        = 4'd0;
    bus.big      = 1'b0;
    bus.big_left = 2'd0;
    bus.score_L  = 1'b1;
    reset_L      = 1'b0;
    repeat (3) @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    check_results("reset", '{res: 4'b0000, num: 5'd0, bsh: 5'd0});

    for (int i = 0; i < 18; i++) begin
      do_shot($sformatf("v%0d", i), vecs[i]);
    end

    // Reset in the middle of a scan aborts it and clears all state.
    @(negedge clock);
    bus.x       = 4'd5;
    bus.y       = 4'd5;
    bus.big     = 1'b0;
    bus.score_L = 1'b0;
    repeat (6) @(negedge clock);
    check("midscan.busy", 32'(bus.busy), 32'd1);
    #2 reset_L = 1'b0;
    #1;
    check_results("midreset", '{res: 4'b0000, num: 5'd0, bsh: 5'd0});
    bus.score_L = 1'b1;
    repeat (3) @(negedge clock);
    reset_L = 1'b1;
    repeat (4) @(negedge clock);
    check_results("postreset", '{res: 4'b0000, num: 5'd0, bsh: 5'd0});
    rv = '{4'd3, 4'd1, 1'b0, 2'd0, 1'b0, 4'b1000, 5'd1, 5'b10000};
    do_shot("after_reset", rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
